// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU top: bus widths, ALU opcodes and
// the command-sequencer state encoding.
package alu_pkg;

    localparam int NB_DATA_BUS = 8;
    localparam int NB_OPCODE   = 6;
    localparam int NB_STATE    = 3;

    localparam logic [NB_OPCODE-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OPCODE-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OPCODE-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OPCODE-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OPCODE-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OPCODE-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OPCODE-1:0] OP_SRL = 6'b000010;
    localparam logic [NB_OPCODE-1:0] OP_NOR = 6'b100111;

    // Codes 5-7 are unused; the sequencer falls back to ST_IDLE from them.
    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE   = 3'd0,
        ST_GET_B  = 3'd1,
        ST_GET_OP = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SEND   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Byte link between the UART-side receiver/transmitter and the command sequencer.
// Handshake: rx is a one-cycle pulse per byte with no backpressure; tx moves one
// byte on every rising edge where o_tx_valid & i_tx_ready, and o_tx_data stays
// stable while o_tx_valid is high and i_tx_ready is low.
interface alu_cmd_sequencer_if #(
    parameter int NB_DATA_BUS = 8
) ();

    logic [NB_DATA_BUS-1:0] i_rx_data;
    logic                   i_rx_valid;
    logic [NB_DATA_BUS-1:0] o_tx_data;
    logic                   o_tx_valid;
    logic                   i_tx_ready;

    // Byte-link side: receiver and transmitter.
    modport master (
        output i_rx_data,
        output i_rx_valid,
        output i_tx_ready,
        input  o_tx_data,
        input  o_tx_valid
    );

    // Sequencer side.
    modport slave (
        input  i_rx_data,
        input  i_rx_valid,
        input  i_tx_ready,
        output o_tx_data,
        output o_tx_valid
    );

endinterface

// File: rtl/alu_seq_timeout.sv
// Inter-byte timeout counter: counts enabled cycles and raises expire
// combinationally on the last allowed idle cycle.
module alu_seq_timeout #(
    parameter int NB_TIMEOUT     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic i_clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [NB_TIMEOUT-1:0] LAST_COUNT = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    logic [NB_TIMEOUT-1:0] count;

    always_ff @(posedge i_clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Clear has priority, so a byte in the expiry cycle suppresses expire.
    assign expire = enable && !clear && (count == LAST_COUNT);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Assembles (A, B, opcode) from the serial byte stream, fires the ALU for one
// cycle, then hands the captured result to the byte transmitter.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int NB_DATA_BUS    = alu_pkg::NB_DATA_BUS,
    parameter int NB_OPCODE      = alu_pkg::NB_OPCODE,
    parameter int NB_TIMEOUT     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                   i_clock,
    input  logic                   reset,
    alu_cmd_sequencer_if.slave     link,
    output logic [NB_DATA_BUS-1:0] o_first_operator,
    output logic [NB_DATA_BUS-1:0] o_second_operator,
    output logic [NB_OPCODE-1:0]   o_opcode,
    output logic                   o_alu_valid,
    input  logic [NB_DATA_BUS-1:0] i_alu_result,
    output logic [NB_STATE-1:0]    o_state,
    output logic                   o_timeout_err,
    output logic                   o_overrun_err
);

    seq_state_t             state_q;
    logic [NB_DATA_BUS-1:0] tx_data_q;
    logic                   in_wait;
    logic                   tmo_clear;
    logic                   tmo_enable;
    logic                   tmo_expire;

    // Only the mid-command byte waits are timed; any accepted byte restarts the window.
    assign in_wait    = (state_q == ST_GET_B) || (state_q == ST_GET_OP);
    assign tmo_clear  = !in_wait || link.i_rx_valid;
    assign tmo_enable = in_wait && !link.i_rx_valid;

    alu_seq_timeout #(
        .NB_TIMEOUT     (NB_TIMEOUT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clock (i_clock),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expire  (tmo_expire)
    );

    always_ff @(posedge i_clock) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            o_first_operator  <= '0;
            o_second_operator <= '0;
            o_opcode          <= '0;
            tx_data_q         <= '0;
            o_timeout_err     <= 1'b0;
            o_overrun_err     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (link.i_rx_valid) begin
                        o_first_operator <= link.i_rx_data;
                        o_timeout_err    <= 1'b0;
                        state_q          <= ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    if (link.i_rx_valid) begin
                        o_second_operator <= link.i_rx_data;
                        state_q           <= ST_GET_OP;
                    end else if (tmo_expire) begin
                        o_timeout_err <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_GET_OP: begin
                    if (link.i_rx_valid) begin
                        o_opcode <= link.i_rx_data[NB_OPCODE-1:0];
                        state_q  <= ST_EXEC;
                    end else if (tmo_expire) begin
                        o_timeout_err <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (link.i_rx_valid) o_overrun_err <= 1'b1;
                    tx_data_q <= i_alu_result;
                    state_q   <= ST_SEND;
                end
                ST_SEND: begin
                    if (link.i_rx_valid) o_overrun_err <= 1'b1;
                    if (link.i_tx_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_alu_valid     = (state_q == ST_EXEC);
    assign link.o_tx_valid = (state_q == ST_SEND);
    assign link.o_tx_data  = tx_data_q;
    assign o_state         = state_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a reference ALU closing the loop
// and a scoreboard on transmitted result bytes.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int W = 8;

    logic           clk;
    logic           reset;
    logic [W-1:0]   first_op;
    logic [W-1:0]   second_op;
    logic [5:0]     opcode;
    logic           alu_valid;
    logic [W-1:0]   alu_result;
    logic [2:0]     state;
    logic           timeout_err;
    logic           overrun_err;

    int             n_compared   = 0;
    int             n_mismatched = 0;
    int             alu_pulses   = 0;
    int             valid_cycles = 0;
    int             transfers    = 0;
    logic [W-1:0]   exp_q[$];

    alu_cmd_sequencer_if #(.NB_DATA_BUS(W)) link ();

    alu_cmd_sequencer #(
        .NB_DATA_BUS    (W),
        .NB_OPCODE      (6),
        .NB_TIMEOUT     (16),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clock           (clk),
        .reset             (reset),
        .link              (link.slave),
        .o_first_operator  (first_op),
        .o_second_operator (second_op),
        .o_opcode          (opcode),
        .o_alu_valid       (alu_valid),
        .i_alu_result      (alu_result),
        .o_state           (state),
        .o_timeout_err     (timeout_err),
        .o_overrun_err     (overrun_err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU standing in for the real one at the serial top.
    function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SRA:  return W'($signed(a) >>> b);
            OP_SRL:  return a >> b;
            OP_NOR:  return ~(a | b);
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu_model(first_op, second_op, opcode);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [W-1:0] b);
        link.i_rx_data  = b;
        link.i_rx_valid = 1'b1;
        tick();
        link.i_rx_valid = 1'b0;
    endtask

    task automatic clear_counts();
        alu_pulses   = 0;
        valid_cycles = 0;
        transfers    = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"},   32'(state),           32'd0);
        check({tag, "_a"},       32'(first_op),        32'd0);
        check({tag, "_b"},       32'(second_op),       32'd0);
        check({tag, "_op"},      32'(opcode),          32'd0);
        check({tag, "_aluv"},    32'(alu_valid),       32'd0);
        check({tag, "_txd"},     32'(link.o_tx_data),  32'd0);
        check({tag, "_txv"},     32'(link.o_tx_valid), 32'd0);
        check({tag, "_tmo"},     32'(timeout_err),     32'd0);
        check({tag, "_ovr"},     32'(overrun_err),     32'd0);
    endtask

    // Scoreboard / monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (alu_valid) alu_pulses++;
            if (link.o_tx_valid) valid_cycles++;
            if (link.o_tx_valid && link.i_tx_ready) begin
                transfers++;
                if (exp_q.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
                else check("tx_data", 32'(link.o_tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        reset           = 1'b1;
        link.i_rx_data  = '0;
        link.i_rx_valid = 1'b0;
        link.i_tx_ready = 1'b1;
        repeat (3) tick();
        check_reset_state("rst");
        reset = 1'b0;
        tick();

        // 1: 5 + 3, ready held high
        clear_counts();
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        check("t1_exec_state", 32'(state), 32'd3);
        check("t1_aluv", 32'(alu_valid), 32'd1);
        check("t1_a", 32'(first_op), 32'h05);
        check("t1_b", 32'(second_op), 32'h03);
        check("t1_op", 32'(opcode), 32'h20);
        exp_q.push_back(8'h08);
        tick();
        check("t1_send_state", 32'(state), 32'd4);
        check("t1_txv", 32'(link.o_tx_valid), 32'd1);
        check("t1_txd", 32'(link.o_tx_data), 32'h08);
        tick();
        check("t1_idle", 32'(state), 32'd0);
        check("t1_txv_low", 32'(link.o_tx_valid), 32'd0);
        check("t1_pulses", 32'(alu_pulses), 32'd1);
        check("t1_transfers", 32'(transfers), 32'd1);

        // 2: 0xF0 - 0x0F with 10 cycles of backpressure
        clear_counts();
        link.i_tx_ready = 1'b0;
        send_byte(8'hF0);
        send_byte(8'h0F);
        send_byte(8'h22);
        exp_q.push_back(8'hE1);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_txd", 32'(link.o_tx_data), 32'hE1);
            tick();
        end
        link.i_tx_ready = 1'b1;
        tick();
        check("t2_idle", 32'(state), 32'd0);
        check("t2_valid_cycles", 32'(valid_cycles), 32'd11);
        check("t2_transfers", 32'(transfers), 32'd1);

        // 3: timeout in GET_B, then recovery
        send_byte(8'h05);
        repeat (15) tick();
        check("t3_before_expiry", 32'(state), 32'd1);
        tick();
        check("t3_expired_state", 32'(state), 32'd0);
        check("t3_tmo_set", 32'(timeout_err), 32'd1);
        check("t3_a_kept", 32'(first_op), 32'h05);
        send_byte(8'h07);
        check("t3_tmo_clear", 32'(timeout_err), 32'd0);
        check("t3_a_new", 32'(first_op), 32'h07);
        send_byte(8'h01);
        send_byte(8'h20);
        exp_q.push_back(8'h08);
        repeat (2) tick();

        // 4: B arrives exactly in the expiry cycle
        send_byte(8'h10);
        repeat (15) tick();
        send_byte(8'h02);
        check("t4_state", 32'(state), 32'd2);
        check("t4_b", 32'(second_op), 32'h02);
        check("t4_tmo", 32'(timeout_err), 32'd0);
        send_byte(8'h22);
        exp_q.push_back(8'h0E);
        repeat (2) tick();

        // 5: overrun byte during SEND
        clear_counts();
        link.i_tx_ready = 1'b0;
        send_byte(8'h0C);
        send_byte(8'h0A);
        send_byte(8'h26);
        exp_q.push_back(8'h06);
        tick();
        check("t5_ovr_before", 32'(overrun_err), 32'd0);
        send_byte(8'hAA);
        check("t5_ovr_set", 32'(overrun_err), 32'd1);
        check("t5_state", 32'(state), 32'd4);
        check("t5_a", 32'(first_op), 32'h0C);
        check("t5_b", 32'(second_op), 32'h0A);
        check("t5_op", 32'(opcode), 32'h26);
        check("t5_txd", 32'(link.o_tx_data), 32'h06);
        link.i_tx_ready = 1'b1;
        tick();
        check("t5_idle", 32'(state), 32'd0);
        check("t5_transfers", 32'(transfers), 32'd1);
        check("t5_ovr_sticky", 32'(overrun_err), 32'd1);

        // 6: reset in GET_OP, then a fresh command with opcode byte 0xE4
        send_byte(8'h11);
        send_byte(8'h22);
        check("t6_get_op", 32'(state), 32'd2);
        reset = 1'b1;
        tick();
        check_reset_state("t6_rst");
        reset = 1'b0;
        tick();
        send_byte(8'h3C);
        send_byte(8'h0F);
        send_byte(8'hE4);
        check("t6_op", 32'(opcode), 32'h24);
        exp_q.push_back(8'h0C);
        repeat (3) tick();
        check("t6_idle", 32'(state), 32'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
